// File: rtl/switch_fabric_pkg.sv
// Shared flit-format helpers for the switch-fabric path: field offsets within one
// fabric flit slot and the packetizer FSM state type.
package switch_fabric_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } pkt_state_e;

    // Slot layout, MSB to LSB: valid, head, tail, vc, dest/extra, data.
    function automatic int flit_width(int dw, int aw, int vw);
        return dw + aw + vw + 3;
    endfunction

    function automatic int dest_pos(int dw);
        return dw;
    endfunction

    function automatic int vc_pos(int dw, int aw);
        return dw + aw;
    endfunction

    function automatic int tail_pos(int dw, int aw, int vw);
        return dw + aw + vw;
    endfunction

    function automatic int head_pos(int dw, int aw, int vw);
        return dw + aw + vw + 1;
    endfunction

    function automatic int valid_pos(int dw, int aw, int vw);
        return dw + aw + vw + 2;
    endfunction

endpackage

// File: rtl/flit_slot_pack.sv
// Combinational assembly of one fabric flit slot from its individual fields.
module flit_slot_pack
    import switch_fabric_pkg::*;
#(
    parameter int DATA_WIDTH       = 128,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    localparam int FW = flit_width(DATA_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH)
) (
    input  logic                        valid,
    input  logic                        head,
    input  logic                        tail,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc,
    input  logic [ADDRESS_WIDTH-1:0]    dest,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic [FW-1:0]               slot
);

    assign slot = {valid, head, tail, vc, dest, data};

endmodule

// File: rtl/flit_packetizer.sv
// Packs a one-flit-per-cycle packet stream into NOC_SPEEDUP-slot fabric bundles behind a
// registered output. Define FLIT_PACKETIZER_TIMEOUT_EN to flush idle partial bundles.
module flit_packetizer
    import switch_fabric_pkg::*;
#(
    parameter int DATA_WIDTH       = 128,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int NOC_SPEEDUP      = 4,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_head,
    input  logic                        i_tail,
    input  logic [ADDRESS_WIDTH-1:0]    i_dest,
    input  logic [ADDRESS_WIDTH-1:0]    i_extra,
    input  logic [VC_ADDRESS_WIDTH-1:0] i_vc,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [NOC_SPEEDUP*(DATA_WIDTH+ADDRESS_WIDTH+VC_ADDRESS_WIDTH+3)-1:0] o_bundle,
    output logic                        o_err,
    output logic                        dbg_state
);

    localparam int FW       = flit_width(DATA_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int BW       = NOC_SPEEDUP * FW;
    localparam int CW       = $clog2(NOC_SPEEDUP);
    localparam int TAIL_BIT = tail_pos(DATA_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NOC_SPEEDUP - 1);

    pkt_state_e                  state_q, state_d;
    logic [CW-1:0]               fill_q, fill_d;
    logic [BW-1:0]               acc_q, acc_d, acc_wr, acc_forced, out_q, out_d;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
    logic                        out_valid_q, out_valid_d, err_q, err_d, ready_en_q;
    logic [FW-1:0]               wr_slot;
    logic                        out_free, drop, abort, abort_fire, close_would, accept;

    flit_slot_pack #(
        .DATA_WIDTH      (DATA_WIDTH),
        .ADDRESS_WIDTH   (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH)
    ) u_slot (
        .valid(1'b1),
        .head (i_head),
        .tail (i_tail),
        .vc   (i_head ? i_vc : vc_q),
        .dest (i_head ? i_dest : i_extra),
        .data (i_data),
        .slot (wr_slot)
    );

    // Both streams use valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; the sender keeps valid and payload steady until it does.
    assign out_free    = !out_valid_q || i_ready;
    assign drop        = i_valid && !i_head && (state_q == IDLE);
    assign abort       = i_valid && i_head && (state_q == PKT) && (fill_q != '0);
    assign abort_fire  = ready_en_q && abort && out_free;
    assign close_would = (fill_q == LAST_SLOT) || (i_valid && i_tail) || abort;
    // A head+tail arriving mid-packet waits one cycle so the truncated bundle and the
    // single-flit bundle never compete for the output register.
    assign o_ready     = ready_en_q &&
                         (drop || (!(out_valid_q && !i_ready && close_would) && !(abort && i_tail)));
    assign accept      = i_valid && o_ready;

`ifdef FLIT_PACKETIZER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_fire;

    assign tmo_fire = (state_q == PKT) && (fill_q != '0) && !accept &&
                      (tcnt_q == TW'(TIMEOUT_CYCLES)) && out_free;

    always_comb begin
        tcnt_d = tcnt_q;
        if (accept || tmo_fire || abort_fire)
            tcnt_d = '0;
        else if ((state_q == PKT) && (fill_q != '0) && (tcnt_q != TW'(TIMEOUT_CYCLES)))
            tcnt_d = tcnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        acc_wr = acc_q;
        acc_wr[fill_q*FW +: FW] = wr_slot;
        acc_forced = acc_q;
        for (int k = 0; k < NOC_SPEEDUP; k++) begin
            if (CW'(k) == fill_q - CW'(1)) acc_forced[k*FW + TAIL_BIT] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        vc_d        = vc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !i_ready;
        err_d       = 1'b0;
        if (accept && drop) begin
            err_d = 1'b1;
        end else if (abort_fire) begin
            out_d       = acc_forced;
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
            state_d     = IDLE;
            if (!i_tail) begin
                acc_d[FW-1:0] = wr_slot;
                fill_d        = CW'(1);
                vc_d          = i_vc;
                state_d       = PKT;
            end
        end else if (accept) begin
            if (i_head) begin
                vc_d = i_vc;
                if (state_q == PKT) err_d = 1'b1;
            end
            if (close_would) begin
                out_d       = acc_wr;
                out_valid_d = 1'b1;
                acc_d       = '0;
                fill_d      = '0;
            end else begin
                acc_d  = acc_wr;
                fill_d = fill_q + CW'(1);
            end
            state_d = i_tail ? IDLE : PKT;
`ifdef FLIT_PACKETIZER_TIMEOUT_EN
        end else if (tmo_fire) begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            acc_q       <= '0;
            vc_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            vc_q        <= vc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_bundle  = out_q;
    assign o_err     = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Self-checking bench for flit_packetizer: directed vectors, a packet table and random
// traffic scored against a queue-based bundle model.
module tb_flit_packetizer;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam int VW = 1;
    localparam int NS = 4;
    localparam int TMO = 16;
    localparam int FW = DW + AW + VW + 3;
    localparam int BW = NS * FW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid, o_ready, i_head, i_tail, o_valid, i_ready, o_err, dbg_state;
    logic [DW-1:0] i_data;
    logic [AW-1:0] i_dest, i_extra;
    logic [VW-1:0] i_vc;
    logic [BW-1:0] o_bundle;

    flit_packetizer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW),
        .NOC_SPEEDUP(NS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_head(i_head), .i_tail(i_tail), .i_dest(i_dest), .i_extra(i_extra), .i_vc(i_vc),
        .o_valid(o_valid), .i_ready(i_ready), .o_bundle(o_bundle), .o_err(o_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic          head;
        logic          tail;
        logic [AW-1:0] dest;
        logic [AW-1:0] extra;
        logic [VW-1:0] vc;
        logic [DW-1:0] data;
    } flit_t;

    typedef struct {
        int            len;
        logic [AW-1:0] dest;
        logic [VW-1:0] vc;
        int            exp_bundles;
        int            exp_last_slots;
    } vec_t;

    int            nchecks = 0;
    int            nerrors = 0;
    logic [BW-1:0] exp_q[$];
    logic [FW-1:0] cur_q[$];
    bit            in_pkt = 0;
    logic [VW-1:0] pkt_vc = '0;
    int            exp_err = 0;
    int            err_seen = 0;
    int            bundles_seen = 0;
    int            ready_drops = 0;
    logic [BW-1:0] last_bundle = '0;

    task automatic check(string name, logic [BW-1:0] got, logic [BW-1:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model (packet rules, order only) ----------------
    function automatic flit_t mkf(logic h, logic t, logic [AW-1:0] d, logic [AW-1:0] x,
                                  logic [VW-1:0] v);
        flit_t f;
        f.head = h; f.tail = t; f.dest = d; f.extra = x; f.vc = v;
        f.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        return f;
    endfunction

    function automatic void push_bundle();
        logic [BW-1:0] b = '0;
        foreach (cur_q[k]) b[k*FW +: FW] = cur_q[k];
        exp_q.push_back(b);
        cur_q.delete();
    endfunction

    function automatic void model_accept(flit_t f);
        logic [FW-1:0] t;
        if (!in_pkt && !f.head) begin
            exp_err++;
            return;
        end
        if (f.head && in_pkt) begin
            exp_err++;
            if (cur_q.size() > 0) begin
                t = cur_q.pop_back();
                t[FW-3] = 1'b1;
                cur_q.push_back(t);
                push_bundle();
            end
        end
        if (f.head) pkt_vc = f.vc;
        cur_q.push_back({1'b1, f.head, f.tail, pkt_vc, (f.head ? f.dest : f.extra), f.data});
        if (f.tail || cur_q.size() == NS) push_bundle();
        in_pkt = !f.tail;
    endfunction

    function automatic bit would_close(flit_t f);
        if (!in_pkt && !f.head) return 1'b0;
        if (f.head && in_pkt && cur_q.size() > 0) return 1'b1;
        return f.tail || (cur_q.size() == NS - 1);
    endfunction

    function automatic int nvalid(logic [BW-1:0] b);
        int n = 0;
        for (int k = 0; k < NS; k++) n += int'(b[k*FW + FW-1]);
        return n;
    endfunction

    // ---------------- driver ----------------
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(flit_t f);
        int n = 0;
        bit done = 0;
        i_valid = 1'b1; i_head = f.head; i_tail = f.tail; i_dest = f.dest;
        i_extra = f.extra; i_vc = f.vc; i_data = f.data;
        while (!done && n < 200) begin
            @(negedge clk);
            if (o_ready) begin
                model_accept(f);
                done = 1;
            end else begin
                check("ready_low_only_on_close", would_close(f), 1);
                ready_drops++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        if (!done) check("send_accept_timeout", 0, 1);
    endtask

    task automatic send_packet(int len, logic [AW-1:0] dest, logic [VW-1:0] vc);
        for (int i = 0; i < len; i++)
            send(mkf(i == 0, i == len - 1, dest, AW'($urandom_range(0, 15)), vc));
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          held_v = 0;
    logic [BW-1:0] held_b = '0;

    always begin
        logic          mv, mr, me, rs;
        logic [BW-1:0] mb;
        @(negedge clk);
        mv = o_valid; mb = o_bundle; mr = i_ready; me = o_err; rs = rstn;
        #1;
        if (!rs) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                check("hold_valid", mv, 1);
                check("hold_bundle", mb, held_b);
            end
            held_v = mv && !mr;
            held_b = mb;
            if (me) err_seen++;
            if (mv && mr) begin
                bundles_seen++;
                last_bundle = mb;
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL unexpected_bundle: got %0h expected none", mb);
                end else begin
                    check("bundle", mb, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    vec_t vecs[6];
    bit   rand_done = 0;

    initial begin
        int b0, rem, r;
        vecs[0] = '{1, 4'h3, 1'b1, 1, 1};
        vecs[1] = '{3, 4'hA, 1'b0, 1, 3};
        vecs[2] = '{4, 4'h1, 1'b1, 1, 4};
        vecs[3] = '{5, 4'hF, 1'b0, 2, 1};
        vecs[4] = '{8, 4'h7, 1'b1, 2, 4};
        vecs[5] = '{9, 4'h2, 1'b1, 3, 1};

        rstn = 1'b0; i_valid = 0; i_head = 0; i_tail = 0; i_dest = '0; i_extra = '0;
        i_vc = '0; i_data = '0; i_ready = 1'b1;
        idle(3);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_bundle", o_bundle, 0);
        check("reset_o_err", o_err, 0);
        check("reset_o_ready", o_ready, 0);
        check("reset_state", dbg_state, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", o_ready, 1);
        idle(2);

        // 8-flit packet: two full bundles, output one cycle after the 4th and 8th accept
        for (int i = 0; i < 8; i++) begin
            send(mkf(i == 0, i == 7, 4'h5, AW'(i), 1'b0));
            if (i == 2) check("no_valid_before_4th", o_valid, 0);
            if (i == 3) begin
                check("valid_after_4th", o_valid, 1);
                check("b1_slot0_head", o_bundle[FW-2], 1);
                check("b1_slot0_dest", o_bundle[DW +: AW], 4'h5);
            end
            if (i == 7) begin
                check("valid_after_8th", o_valid, 1);
                check("b2_slot3_tail", o_bundle[3*FW + FW-3], 1);
            end
        end
        idle(3);

        // 3-flit packet: slots 0-2 valid, slot 2 tail, slot 3 zero
        send_packet(3, 4'h9, 1'b0);
        check("p3_slot2_tail", o_bundle[2*FW + FW-3], 1);
        check("p3_slot3_zero", o_bundle[3*FW +: FW], 0);
        idle(3);

        // single head+tail on vc 1
        send(mkf(1'b1, 1'b1, 4'hC, 4'h0, 1'b1));
        check("single_head_tail_vc", {o_bundle[FW-2], o_bundle[FW-3], o_bundle[DW+AW]}, 3'b111);
        check("single_state_idle", dbg_state, 0);
        idle(3);

        foreach (vecs[v]) begin
            b0 = bundles_seen;
            send_packet(vecs[v].len, vecs[v].dest, vecs[v].vc);
            idle(3);
            check($sformatf("tbl%0d_bundles", v), bundles_seen - b0, vecs[v].exp_bundles);
            check($sformatf("tbl%0d_slots", v), nvalid(last_bundle), vecs[v].exp_last_slots);
            check($sformatf("tbl%0d_vc", v), last_bundle[DW+AW], vecs[v].vc);
            check($sformatf("tbl%0d_tail", v),
                  last_bundle[(vecs[v].exp_last_slots-1)*FW + FW-3], 1);
        end

        // 12-flit stream with a 5-cycle output stall
        ready_drops = 0;
        fork
            send_packet(12, 4'h4, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        idle(4);
        check("stall_ready_dropped", ready_drops != 0, 1);

        // body flit while idle: dropped with an error pulse
        send(mkf(1'b0, 1'b0, 4'h0, 4'h6, 1'b0));
        check("idle_body_err", o_err, 1);
        check("idle_body_no_bundle", o_valid, 0);
        idle(1);
        check("idle_body_err_oneshot", o_err, 0);
        idle(2);

        // new head after two flits: truncated bundle with slot1 tail forced
        send(mkf(1'b1, 1'b0, 4'h8, 4'h0, 1'b0));
        send(mkf(1'b0, 1'b0, 4'h0, 4'h1, 1'b0));
        idle(2);
        send(mkf(1'b1, 1'b0, 4'hB, 4'h0, 1'b1));
        check("abort_err", o_err, 1);
        check("abort_slot1_tail", o_bundle[FW + FW-3], 1);
        check("abort_slot2_empty", o_bundle[2*FW + FW-1], 0);
        send(mkf(1'b0, 1'b0, 4'h0, 4'h2, 1'b0));
        send(mkf(1'b0, 1'b1, 4'h0, 4'h3, 1'b0));
        idle(3);

        // reset in the middle of a packet discards the partial bundle
        send(mkf(1'b1, 1'b0, 4'h1, 4'h0, 1'b0));
        send(mkf(1'b0, 1'b0, 4'h0, 4'h1, 1'b0));
        idle(2);
        rstn = 1'b0;
        #1;
        check("midreset_o_valid", o_valid, 0);
        check("midreset_state", dbg_state, 0);
        cur_q.delete();
        in_pkt = 0;
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        check("midreset_no_bundle", o_valid, 0);
        send_packet(2, 4'hE, 1'b1);
        idle(3);

`ifdef FLIT_PACKETIZER_TIMEOUT_EN
        send(mkf(1'b1, 1'b0, 4'h6, 4'h0, 1'b0));
        send(mkf(1'b0, 1'b0, 4'h0, 4'h5, 1'b0));
        push_bundle();
        b0 = bundles_seen;
        idle(TMO + 4);
        check("timeout_flush", bundles_seen - b0, 1);
        send(mkf(1'b0, 1'b1, 4'h0, 4'h7, 1'b0));
        check("timeout_next_slot0", nvalid(o_bundle), 1);
        check("timeout_next_tail", o_bundle[FW-3], 1);
        idle(3);
`endif

        // random traffic with occasional protocol errors and random back-pressure
        fork
            begin
                rem = 0;
                for (int n = 0; n < 400; n++) begin
                    r = $urandom_range(0, 15);
                    if (rem == 0) begin
                        if (r == 0) begin
                            send(mkf(1'b0, 1'($urandom_range(0, 1)), 4'h0, AW'($urandom_range(0, 15)), 1'b0));
                        end else begin
                            rem = $urandom_range(1, 9);
                            send(mkf(1'b1, rem == 1, AW'($urandom_range(0, 15)), 4'h0,
                                     VW'($urandom_range(0, 1))));
                            rem--;
                        end
                    end else if (r == 0) begin
                        rem = 0;
                    end else begin
                        send(mkf(1'b0, rem == 1, 4'h0, AW'($urandom_range(0, 15)), 1'b0));
                        rem--;
                    end
                    idle($urandom_range(0, 2));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join

        i_ready = 1'b1;
        idle(10);
        check("scoreboard_drained", exp_q.size(), 0);
        check("err_pulse_count", err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/flit_packetizer.md
Name: flit_packetizer

Overview:
- Sequential successor to the combinational flit aggregator in the switch-fabric path.
- Accepts one flit per cycle from a module-side valid/ready stream, with head/tail markers.
- Packs flits into NOC_SPEEDUP-slot bundles in the fabric flit format (valid, head, tail, VC, dest/extra, data).
- Presents each bundle through a registered valid/ready output toward the fabric port, with per-packet VC and protocol-error detection.

Parameters:
- DATA_WIDTH, 128, payload bits per flit.
- ADDRESS_WIDTH, 4, dest field width; carries extra bits on body flits.
- VC_ADDRESS_WIDTH, 1, VC field width.
- NOC_SPEEDUP, 4, flit slots per bundle (power of two, ≥2).
- TIMEOUT_CYCLES, 16, idle cycles before a partial bundle is flushed (optional feature only).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input flit valid.
- o_ready  out  1  input flit accepted when i_valid&&o_ready.
- i_data  in  DATA_WIDTH  flit payload.
- i_head  in  1  first flit of packet.
- i_tail  in  1  last flit of packet; head&&tail is a single-flit packet.
- i_dest  in  ADDRESS_WIDTH  destination, sampled on head flits only.
- i_extra  in  ADDRESS_WIDTH  side bits, sampled on body/tail flits only.
- i_vc  in  VC_ADDRESS_WIDTH  VC, latched on head and applied to the whole packet.
- o_valid  out  1  bundle valid.
- i_ready  in  1  fabric accepts bundle.
- o_bundle  out  NOC_SPEEDUP*(DATA_WIDTH+ADDRESS_WIDTH+VC_ADDRESS_WIDTH+3)  slot k at bits [k*FW +: FW].
  - Per slot, MSB→LSB: valid, head, tail, vc, dest/extra, data.
- o_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert, sync release):
  - o_valid=0, o_bundle=0, o_err=0.
  - Accumulator cleared, fill count 0, FSM in IDLE.
  - o_ready=1 one cycle after release.
- FSM states:
  - IDLE: waiting for a head flit.
  - PKT: inside a packet.
  - Transitions: IDLE→PKT on an accepted head without tail. PKT→IDLE on an accepted tail. An accepted head+tail stays in IDLE.
- Slot fill:
  - Each accepted flit is written to accumulator slot fill_cnt with valid=1, and fill_cnt increments.
  - Unfilled slots are all-zero; slot valid bit is 0.
- Bundle close: the bundle closes on the flit that fills slot NOC_SPEEDUP-1, or on any tail flit.
  - The closed accumulator moves to the output register in the same edge.
  - fill_cnt resets to 0.
  - A bundle never spans two packets.
- Latency: closing flit accepted at edge N → o_valid=1 after edge N; no combinational path from input to output.
- Output hold: o_bundle/o_valid are held stable while o_valid&&!i_ready.
- o_ready: o_ready = !(o_valid && !i_ready && closing_would_occur).
  - closing_would_occur means fill_cnt==NOC_SPEEDUP-1, or i_tail is asserted with i_valid.
  - Non-closing flits are always accepted.
  - Simultaneous output consume and close: the output register is reloaded with no bubble.
- Errors (o_err pulses one cycle):
  - Body/tail flit in IDLE: flit dropped, ready stays 1.
  - Head flit in PKT:
    - The open bundle closes with its last valid slot's tail forced to 1; if the bundle is empty, nothing is emitted.
    - The new head starts a fresh accumulator in the same cycle.
    - If the output is stalled, o_ready=0 until the stall clears.
- Back-to-back: full throughput of one flit/cycle while i_ready=1.
- Mid-operation reset: all partial state is discarded; no partial bundle is emitted.

Optional Feature:
- Macro FLIT_PACKETIZER_TIMEOUT_EN.
- When defined:
  - A counter increments each cycle in PKT with fill_cnt>0 and no accepted flit.
  - When it reaches TIMEOUT_CYCLES and the output register is free or being consumed, the partial bundle is emitted with tail bits unchanged.
  - The packet continues in PKT.
  - The counter clears on any accepted flit or on emission.
- When undefined: no counter; partial bundles wait for a fill or a tail.

Decomposition:
- Package switch_fabric_pkg:
  - flit field bit-position localparams (VALID/HEAD/TAIL/VC/DEST offsets) as functions of widths.
  - Typedef enum pkt_state_e {IDLE, PKT}.
  - Function for flit width.
- Sub-module flit_slot_pack: pure combinational build of one slot from (valid, head, tail, vc, dest/extra, data); instantiated once for the write slot.

Test Plan:
- NOC_SPEEDUP=4, 8-flit packet, i_ready=1 → two bundles.
  - Bundle 1: slot0 head=1 with dest=0x5.
  - Bundle 2: slot3 tail=1.
  - o_valid one cycle after the 4th and 8th accept.
- 3-flit packet → one bundle with slots0-2 valid, slot2 tail, slot3 all-zero.
- Single head+tail flit with i_vc=1 → slot0 head=tail=1, vc=1; FSM stays IDLE.
- Hold i_ready=0 for 5 cycles during a 12-flit stream:
  - o_bundle stable throughout.
  - o_ready drops only on closing flits.
  - No flit lost or duplicated (scoreboard).
- Body flit in IDLE → o_err pulse, flit dropped.
- Head during PKT after 2 flits → bundle with slot1 forced tail=1, o_err pulse, new packet starts at slot0.
- With FLIT_PACKETIZER_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - 1 body flit, then idle 16 cycles → partial bundle emitted.
  - Next flit lands in slot0.
